vga_vsync_gen: RTL and testbench
================================

// Module: vga_vsync_gen
// PURPOSE
//   Downstream stage of the VGA horizontal counter. Consumes hCount/endOfLine and
//   produces the vertical count, registered hsync/vsync, active-video flag and pixel
//   coordinates for 640x480@60Hz. Also emits a frame-start pulse and a generation tick
//   every GEN_FRAMES frames that paces the Game of Life update engine.
// PARAMETERS
//   H_ACTIVE    640  visible pixels per line
//   H_FP        16   horizontal front porch (pixels)
//   H_SYNC      96   horizontal sync width (pixels)
//   H_BP        48   horizontal back porch; H_TOTAL = sum of the four = 800
//   V_ACTIVE    480  visible lines per frame
//   V_FP        10   vertical front porch (lines)
//   V_SYNC      2    vertical sync width (lines)
//   V_BP        33   vertical back porch; V_TOTAL = sum of the four = 525
//   SYNC_POL    0    active level of hsync/vsync (0 = active-low)
//   GEN_FRAMES  30   frames per genTick, valid range 1..255
// PORTS
//   pixelClk    in   1   25 MHz pixel clock
//   rstN        in   1   synchronous active-low reset
//   hCount      in   10  horizontal count 0..H_TOTAL-1 from the horizontal counter
//   endOfLine   in   1   high while hCount == H_TOTAL-1
//   genEnable   in   1   1 = frame counter runs; 0 = frame counter holds, genTick stays 0
//   vCount      out  10  vertical count 0..V_TOTAL-1 (internal register, unlagged)
//   hsync       out  1   registered horizontal sync
//   vsync       out  1   registered vertical sync
//   videoOn     out  1   registered active-video flag
//   pixelX      out  10  registered column, valid while videoOn
//   pixelY      out  9   registered row, valid while videoOn
//   frameStart  out  1   one-cycle pulse, aligned with pixel (0,0)
//   genTick     out  1   one-cycle pulse, every GEN_FRAMES-th frameStart
// BEHAVIOUR
//   Clocking/reset: every register updates on posedge pixelClk. While rstN==0: vCount=0,
//     hsync=vsync=~SYNC_POL, videoOn=0, pixelX=0, pixelY=0, frameStart=0, genTick=0,
//     internal frameCnt=0. Reset applied mid-frame has the same effect. After release,
//     vCount starts at 0 regardless of hCount phase. The first line may be short.
//   vCount: endOfLine==1 -> vCount==V_TOTAL-1 ? 0 : vCount+1; otherwise hold. Therefore
//     vCount changes on the same edge at which hCount wraps 799->0.
//   Decode of the current (hCount, vCount) is combinational and registered once.
//     All registered outputs lag hCount by exactly 1 cycle and stay mutually aligned.
//     hsync = SYNC_POL when H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC
//       (656..751); else ~SYNC_POL.
//     vsync = SYNC_POL when V_ACTIVE+V_FP <= vCount < V_ACTIVE+V_FP+V_SYNC
//       (490..491), for the entire line; else ~SYNC_POL.
//     videoOn = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
//     pixelX/pixelY = hCount / vCount[8:0] when videoOn; otherwise 0.
//     frameStart = 1 when hCount==0 && vCount==0 (registered, so it is high in the
//       cycle where pixelX=0, pixelY=0, videoOn=1).
//   Frame counter (8 bit): updates only on a cycle where the decoded frameStart is true.
//     If genEnable==0: hold, genTick=0.
//     If frameCnt==GEN_FRAMES-1: frameCnt<=0 and genTick=1 (same cycle as frameStart).
//     Otherwise frameCnt<=frameCnt+1.
//     genEnable is sampled only at frame start. Toggling it mid-frame has no effect
//     until the next frame start.
//   hCount >= H_TOTAL (illegal input): decode as blanking (videoOn=0, hsync inactive),
//     vCount unaffected unless endOfLine is asserted.
//   Arithmetic is unsigned. Porch sums are computed as localparams. No carries escape
//     the 10-bit counters.
// TESTING
//   1. Hold rstN=0 for 3 clocks with hCount running -> all outputs at reset values,
//      hsync=vsync=1.
//   2. Drive hCount 0..799 with endOfLine at 799 -> hsync low for exactly 96 cycles,
//      first low cycle when delayed hCount = 656. videoOn high 640 cycles per visible line.
//   3. Run one full frame -> vCount wraps 524->0. vsync low for 1600 cycles, starting at
//      the line where vCount = 490. frameStart exactly once per 420000 cycles.
//   4. GEN_FRAMES=3, genEnable=1, run 7 frames -> genTick on frames 3 and 6 only,
//      coincident with frameStart.
//   5. Clear genEnable for frames 2-4, then set it -> genTick delayed by 3 frames.
//      frameCnt holds across the gap.
//   6. Assert rstN=0 at vCount=300, hCount=400 for 1 cycle -> next cycle vCount=0, then
//      counting resumes. frameStart appears only at the next hCount==0 with vCount==0.

Source files
------------

// File: rtl/vga_vsync_gen.sv
// Vertical timing stage: vCount, registered syncs/video/coords, frameStart and genTick pacing.
// Latency: decoded outputs lag hCount by one cycle; no backpressure, free-running pixel pipeline.
module vga_vsync_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   GEN_FRAMES = 30
) (
  input  logic       pixelClk,
  input  logic       rstN,
  input  logic [9:0] hCount,
  input  logic       endOfLine,
  input  logic       genEnable,
  output logic [9:0] vCount,
  output logic       hsync,
  output logic       vsync,
  output logic       videoOn,
  output logic [9:0] pixelX,
  output logic [8:0] pixelY,
  output logic       frameStart,
  output logic       genTick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] L_H_TOTAL  = 10'(H_TOTAL);
  localparam logic [9:0] L_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] L_HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] L_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] L_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0] L_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] L_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] L_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [7:0] L_GEN_LAST = 8'(GEN_FRAMES - 1);

  logic [9:0] r_vcount;
  logic [7:0] r_frame_cnt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic [9:0] r_pixel_x;
  logic [8:0] r_pixel_y;
  logic       r_frame_start;
  logic       r_gen_tick;

  logic       w_h_legal;
  logic       w_hsync_act;
  logic       w_vsync_act;
  logic       w_video;
  logic       w_frame_start;
  logic       w_gen_tick;
  logic [7:0] w_frame_cnt_nxt;
  logic [9:0] w_vcount_nxt;

  // Out-of-range hCount decodes as blanking with sync inactive.
  assign w_h_legal     = (hCount < L_H_TOTAL);
  assign w_hsync_act   = w_h_legal && (hCount >= L_HS_START) && (hCount < L_HS_END);
  assign w_vsync_act   = (r_vcount >= L_VS_START) && (r_vcount < L_VS_END);
  assign w_video       = w_h_legal && (hCount < L_H_ACTIVE) && (r_vcount < L_V_ACTIVE);
  assign w_frame_start = (hCount == 10'd0) && (r_vcount == 10'd0);
  assign w_vcount_nxt  = (r_vcount == L_V_LAST) ? 10'd0 : r_vcount + 10'd1;

  // genEnable only matters on the frame-start cycle; the count holds otherwise.
  always_comb begin
    w_frame_cnt_nxt = r_frame_cnt;
    w_gen_tick      = 1'b0;
    if (w_frame_start && genEnable) begin
      if (r_frame_cnt == L_GEN_LAST) begin
        w_frame_cnt_nxt = 8'd0;
        w_gen_tick      = 1'b1;
      end else begin
        w_frame_cnt_nxt = r_frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge pixelClk) begin
    if (!rstN) begin
      r_vcount      <= 10'd0;
      r_frame_cnt   <= 8'd0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_pixel_x     <= 10'd0;
      r_pixel_y     <= 9'd0;
      r_frame_start <= 1'b0;
      r_gen_tick    <= 1'b0;
    end else begin
      if (endOfLine) begin
        r_vcount <= w_vcount_nxt;
      end
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_hsync       <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= w_video;
      r_pixel_x     <= w_video ? hCount : 10'd0;
      r_pixel_y     <= w_video ? r_vcount[8:0] : 9'd0;
      r_frame_start <= w_frame_start;
      r_gen_tick    <= w_gen_tick;
    end
  end

  assign vCount     = r_vcount;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign videoOn    = r_video_on;
  assign pixelX     = r_pixel_x;
  assign pixelY     = r_pixel_y;
  assign frameStart = r_frame_start;
  assign genTick    = r_gen_tick;

endmodule

// File: tb/tb_vga_vsync_gen.sv
// Bench for vga_vsync_gen using shrunken timing so many whole frames fit in a short run.
// A reference model pushes expected outputs per driven cycle; each test pops and compares.
module tb_vga_vsync_gen;

  localparam int TH_ACT  = 40;
  localparam int TH_FP   = 4;
  localparam int TH_SYNC = 6;
  localparam int TH_BP   = 10;
  localparam int TH_TOT  = TH_ACT + TH_FP + TH_SYNC + TH_BP;
  localparam int TV_ACT  = 12;
  localparam int TV_FP   = 3;
  localparam int TV_SYNC = 2;
  localparam int TV_BP   = 3;
  localparam int TV_TOT  = TV_ACT + TV_FP + TV_SYNC + TV_BP;
  localparam int TGEN    = 3;
  localparam int FRAME   = TH_TOT * TV_TOT;

  typedef struct packed {
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] px;
    logic [8:0] py;
    logic       fs;
    logic       gt;
  } out_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [9:0] hCount = 10'd0;
  logic       endOfLine = 1'b0;
  logic       genEnable = 1'b1;
  logic [9:0] vCount;
  logic       hsync, vsync, videoOn, frameStart, genTick;
  logic [9:0] pixelX;
  logic [8:0] pixelY;

  out_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   tb_h = TH_TOT - 3;
  int   m_v = 0;
  int   m_fc = 0;

  always #5 clk = ~clk;

  vga_vsync_gen #(
    .H_ACTIVE(TH_ACT), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_ACTIVE(TV_ACT), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
    .SYNC_POL(1'b0), .GEN_FRAMES(TGEN)
  ) dut (
    .pixelClk(clk), .rstN(rstN), .hCount(hCount), .endOfLine(endOfLine),
    .genEnable(genEnable), .vCount(vCount), .hsync(hsync), .vsync(vsync),
    .videoOn(videoOn), .pixelX(pixelX), .pixelY(pixelY),
    .frameStart(frameStart), .genTick(genTick)
  );

  // Reference model: predicts the registered outputs for one driven cycle.
  task automatic drive(input logic rst, input logic [9:0] hc, input logic eol, input logic ge);
    out_t e;
    e = '0;
    if (!rst) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      m_v  = 0;
      m_fc = 0;
    end else begin
      e.hs  = !((hc >= TH_ACT + TH_FP) && (hc < TH_ACT + TH_FP + TH_SYNC));
      e.vs  = !((m_v >= TV_ACT + TV_FP) && (m_v < TV_ACT + TV_FP + TV_SYNC));
      e.von = (hc < TH_ACT) && (m_v < TV_ACT);
      if (e.von) begin
        e.px = hc;
        e.py = 9'(m_v);
      end
      e.fs = (hc == 10'd0) && (m_v == 0);
      if (e.fs && ge) begin
        if (m_fc == TGEN - 1) begin
          m_fc = 0;
          e.gt = 1'b1;
        end else begin
          m_fc = m_fc + 1;
        end
      end
      if (eol) m_v = (m_v == TV_TOT - 1) ? 0 : m_v + 1;
      e.v = 10'(m_v);
    end
    sb_q.push_back(e);
    rstN      = rst;
    hCount    = hc;
    endOfLine = eol;
    genEnable = ge;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rst, input logic ge, output out_t e, output out_t a);
    logic [9:0] hc;
    hc = 10'(tb_h);
    drive(rst, hc, (tb_h == TH_TOT - 1), ge);
    tb_h = (tb_h == TH_TOT - 1) ? 0 : tb_h + 1;
    e = sb_q.pop_front();
    a = {vCount, hsync, vsync, videoOn, pixelX, pixelY, frameStart, genTick};
  endtask

  task automatic test_reset();
    out_t e, a;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %h expected %h", i, a, e);
      end
      vectors++;
      if ({hsync, vsync} !== 2'b11) begin
        miscompares++;
        $display("FAIL reset_sync_idle cyc %0d: got %b expected 11", i, {hsync, vsync});
      end
    end
  endtask

  task automatic test_hsync_line();
    out_t e, a;
    int hs_low = 0, video = 0, first_low = -1, hc_d;
    for (int i = 0; i < TH_TOT; i++) begin
      hc_d = tb_h;
      step(1'b1, 1'b1, e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL hsync_line cyc %0d: got %h expected %h", i, a, e);
      end
      if (!a.hs) begin
        hs_low++;
        if (first_low < 0) first_low = hc_d;
      end
      if (a.von) video++;
    end
    vectors++;
    if (hs_low != TH_SYNC) begin
      miscompares++;
      $display("FAIL hsync_width: got %0d expected %0d", hs_low, TH_SYNC);
    end
    vectors++;
    if (first_low != TH_ACT + TH_FP) begin
      miscompares++;
      $display("FAIL hsync_start: got %0d expected %0d", first_low, TH_ACT + TH_FP);
    end
    vectors++;
    if (video != TH_ACT) begin
      miscompares++;
      $display("FAIL video_width: got %0d expected %0d", video, TH_ACT);
    end
  endtask

  task automatic test_frame();
    out_t e, a;
    int vs_low = 0, fs_cnt = 0, wraps = 0, vs_line = -1, prev_v = -1;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, 1'b1, e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL frame cyc %0d: got %h expected %h", i, a, e);
      end
      if (!a.vs) begin
        if (vs_line < 0) vs_line = int'(a.v);
        vs_low++;
      end
      if (a.fs) fs_cnt++;
      if (prev_v == TV_TOT - 1 && a.v == 10'd0) wraps++;
      prev_v = int'(a.v);
    end
    vectors++;
    if (vs_low != TV_SYNC * TH_TOT) begin
      miscompares++;
      $display("FAIL vsync_width: got %0d expected %0d", vs_low, TV_SYNC * TH_TOT);
    end
    vectors++;
    if (vs_line != TV_ACT + TV_FP) begin
      miscompares++;
      $display("FAIL vsync_line: got %0d expected %0d", vs_line, TV_ACT + TV_FP);
    end
    vectors++;
    if (fs_cnt != 1) begin
      miscompares++;
      $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
    end
    vectors++;
    if (wraps != 1) begin
      miscompares++;
      $display("FAIL vcount_wrap: got %0d expected 1", wraps);
    end
  endtask

  // Out-of-range hCount with endOfLine low: blanking, vCount untouched.
  task automatic test_illegal_hcount();
    out_t e, a;
    logic [9:0] bad [3];
    bad[0] = 10'(TH_TOT);
    bad[1] = 10'd500;
    bad[2] = 10'd1023;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bad[i], 1'b0, 1'b1);
      e = sb_q.pop_front();
      a = {vCount, hsync, vsync, videoOn, pixelX, pixelY, frameStart, genTick};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL illegal_hcount %0d: got %h expected %h", bad[i], a, e);
      end
    end
  endtask

  task automatic test_gentick();
    out_t e, a;
    int fnum = 0, tick_mask = 0, stray = 0;
    do begin
      step(1'b0, 1'b1, e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL gentick_reset: got %h expected %h", a, e);
      end
    end while (tb_h != 0);
    for (int i = 0; i < 7 * FRAME; i++) begin
      step(1'b1, 1'b1, e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL gentick cyc %0d: got %h expected %h", i, a, e);
      end
      if (a.fs) fnum++;
      if (a.gt && a.fs) tick_mask |= (1 << fnum);
      if (a.gt && !a.fs) stray++;
    end
    vectors++;
    if (tick_mask != ((1 << 3) | (1 << 6)) || stray != 0 || fnum != 7) begin
      miscompares++;
      $display("FAIL gentick_frames: got mask %0h stray %0d frames %0d expected mask 48 stray 0 frames 7",
               tick_mask, stray, fnum);
    end
  endtask

  task automatic test_gen_enable();
    out_t e, a;
    int fidx = 0, fnum = 0, tick_mask = 0;
    logic ge;
    do begin
      step(1'b0, 1'b1, e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL gen_enable_reset: got %h expected %h", a, e);
      end
    end while (tb_h != 0);
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (tb_h == 0 && m_v == 0) begin
        fidx++;
        ge = !(fidx >= 2 && fidx <= 4);
      end else begin
        ge = 1'($urandom_range(0, 1));
      end
      step(1'b1, ge, e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL gen_enable cyc %0d: got %h expected %h", i, a, e);
      end
      if (a.fs) fnum++;
      if (a.gt) tick_mask |= (1 << fnum);
    end
    vectors++;
    if (tick_mask != (1 << 6)) begin
      miscompares++;
      $display("FAIL gen_enable_gap: got mask %0h expected 40", tick_mask);
    end
  endtask

  task automatic test_midframe_reset();
    out_t e, a;
    int first_fs = -1, fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME && !(m_v == 7 && tb_h == 25); i++) begin
      step(1'b1, 1'b1, e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL midreset_run cyc %0d: got %h expected %h", i, a, e);
      end
    end
    step(1'b0, 1'b1, e, a);
    vectors++;
    if (a !== e || a.v !== 10'd0) begin
      miscompares++;
      $display("FAIL midreset_pulse: got %h expected %h", a, e);
    end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, 1'b1, e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL midreset_after cyc %0d: got %h expected %h", i, a, e);
      end
      if (a.fs) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = i;
      end
    end
    vectors++;
    if (first_fs != (TH_TOT - 26) + (TV_TOT - 1) * TH_TOT || fs_cnt != 1) begin
      miscompares++;
      $display("FAIL midreset_frame_start: got idx %0d count %0d expected idx %0d count 1",
               first_fs, fs_cnt, (TH_TOT - 26) + (TV_TOT - 1) * TH_TOT);
    end
  endtask

  initial begin
    test_reset();
    test_hsync_line();
    test_frame();
    test_illegal_hcount();
    test_gentick();
    test_gen_enable();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
